// File: rtl/parking_lane_arbiter_if.sv
// Lane-side handshake bundle for parking_lane_arbiter: lane requests and pass
// sensor in, grants, gate command and occupancy status out.
interface parking_lane_arbiter_if #(
    parameter int CNT_W = 4
);
    logic             entryReq;
    logic             exitReq;
    logic             passSensor;
    logic             entryGrant;
    logic             exitGrant;
    logic             gateOpen;
    logic [CNT_W-1:0] occupancy;
    logic             lotFull;
    logic             timeoutAlarm;

    // Lane / sensor side.
    modport master (
        output entryReq, exitReq, passSensor,
        input  entryGrant, exitGrant, gateOpen, occupancy, lotFull, timeoutAlarm
    );

    // Arbiter side.
    modport slave (
        input  entryReq, exitReq, passSensor,
        output entryGrant, exitGrant, gateOpen, occupancy, lotFull, timeoutAlarm
    );
endinterface

// File: rtl/parking_lane_arbiter.sv
// Shares one barrier gate between the entry and exit lanes and tracks lot occupancy.
// Define ARB_TIMEOUT_EN to add an open-gate watchdog that aborts a stalled grant.
module parking_lane_arbiter #(
    parameter int CAPACITY = 8,
    parameter int CNT_W    = 4,
    parameter int TIMEOUT  = 16
) (
    input logic                   clk,
    input logic                   reset_n,
    parking_lane_arbiter_if.slave bus
);
    typedef enum logic [5:0] {
        IDLE       = 6'b000001,
        ENTRY_OPEN = 6'b000010,
        EXIT_OPEN  = 6'b000100,
        PASSING    = 6'b001000,
        CLOSE      = 6'b010000,
        ABORT      = 6'b100000
    } state_t;

    typedef enum logic {
        PRI_EXIT  = 1'b0,
        PRI_ENTRY = 1'b1
    } pri_t;

    localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);

    if (TIMEOUT < 1 || (2 ** CNT_W) <= CAPACITY) begin : gParamCheck
        $error("parking_lane_arbiter: need TIMEOUT >= 1 and 2**CNT_W > CAPACITY");
    end

    state_t           state;
    pri_t             priPtr;
    logic [CNT_W-1:0] occupancy;
    logic             entryGrant;
    logic             exitGrant;
    logic             timeoutAlarm;
    logic             lotFull;
    logic             entryElig;
    logic             exitElig;
    logic             serveEntry;
    logic             grantedReq;

`ifdef ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    logic [WD_W-1:0] wdCnt;
`endif

    assign lotFull    = (occupancy == CAP);
    assign entryElig  = bus.entryReq && !lotFull;
    assign exitElig   = bus.exitReq && (occupancy != '0);
    // Entry wins only when exit cannot be served or the pointer names entry.
    assign serveEntry = entryElig && (!exitElig || priPtr == PRI_ENTRY);
    assign grantedReq = entryGrant ? bus.entryReq : bus.exitReq;

    // NOTE: every register here is assigned with <= so that all next-state logic
    // reads the values from before this edge, whatever the statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            priPtr       <= PRI_EXIT;
            occupancy    <= '0;
            entryGrant   <= 1'b0;
            exitGrant    <= 1'b0;
            timeoutAlarm <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            wdCnt        <= '0;
`endif
        end else begin
            timeoutAlarm <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (entryElig || exitElig) begin
                        state      <= serveEntry ? ENTRY_OPEN : EXIT_OPEN;
                        entryGrant <= serveEntry;
                        exitGrant  <= !serveEntry;
`ifdef ARB_TIMEOUT_EN
                        wdCnt      <= '0;
`endif
                    end
                end
                ENTRY_OPEN, EXIT_OPEN: begin
                    // A car reaching the sensor beats a same-cycle request drop.
                    if (bus.passSensor) begin
                        state <= PASSING;
                    end else if (!grantedReq) begin
                        state      <= ABORT;
                        entryGrant <= 1'b0;
                        exitGrant  <= 1'b0;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (wdCnt == WD_LAST) begin
                        state        <= ABORT;
                        entryGrant   <= 1'b0;
                        exitGrant    <= 1'b0;
                        timeoutAlarm <= 1'b1;
                    end else begin
                        wdCnt <= wdCnt + 1'b1;
                    end
`endif
                end
                PASSING: begin
                    if (!bus.passSensor) begin
                        state      <= CLOSE;
                        entryGrant <= 1'b0;
                        exitGrant  <= 1'b0;
                        priPtr     <= entryGrant ? PRI_EXIT : PRI_ENTRY;
                        // NOTE: the count saturates at both bounds even though
                        // eligibility already keeps it in range.
                        if (entryGrant) begin
                            occupancy <= lotFull ? occupancy : occupancy + 1'b1;
                        end else begin
                            occupancy <= (occupancy == '0) ? occupancy : occupancy - 1'b1;
                        end
                    end
                end
                CLOSE, ABORT: begin
                    state <= IDLE;
                end
                default: begin
                    state      <= IDLE;
                    entryGrant <= 1'b0;
                    exitGrant  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.entryGrant   = entryGrant;
    assign bus.exitGrant    = exitGrant;
    assign bus.gateOpen     = entryGrant | exitGrant;
    assign bus.occupancy    = occupancy;
    assign bus.lotFull      = lotFull;
`ifdef ARB_TIMEOUT_EN
    assign bus.timeoutAlarm = timeoutAlarm;
`else
    assign bus.timeoutAlarm = 1'b0;
`endif
endmodule

// File: tb/tb_parking_lane_arbiter.sv
// Scoreboard bench for parking_lane_arbiter: a lane driver issues random and directed
// gate transactions while a monitor checks each grant and service result.
module tb_parking_lane_arbiter;
    localparam int CAPACITY = 8;
    localparam int CNT_W    = 4;
    localparam int TIMEOUT  = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    parking_lane_arbiter_if #(.CNT_W(CNT_W)) bus ();

    parking_lane_arbiter #(
        .CAPACITY(CAPACITY),
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    typedef struct {
        bit entryLane;
        int occAfter;
    } exp_t;

    exp_t expQ[$];
    int   total = 0;
    int   bad = 0;
    int   modelOcc = 0;
    bit   modelPtrEntry = 1'b0;
    int   trackOcc = 0;
    bit   monitorOn = 1'b0;

    task automatic check(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
        end
    endtask

    // Monitor: compares every grant and every end of service with the scoreboard.
    initial begin
        bit   prevGate = 1'b0;
        int   lowRun = 2;
        exp_t e;
        forever begin
            @(negedge clk);
            if (monitorOn) begin
                if (!bus.gateOpen && prevGate && expQ.size() != 0) begin
                    e = expQ.pop_front();
                    trackOcc = e.occAfter;
                end
                check("occupancy", int'(bus.occupancy), trackOcc);
                check("lotFull", int'(bus.lotFull), int'(trackOcc == CAPACITY));
                check("grants exclusive", int'(bus.entryGrant && bus.exitGrant), 0);
                check("gateOpen", int'(bus.gateOpen), int'(bus.entryGrant || bus.exitGrant));
`ifndef ARB_TIMEOUT_EN
                check("timeoutAlarm idle", int'(bus.timeoutAlarm), 0);
`endif
                if (bus.gateOpen && !prevGate) begin
                    check("gate low cycles before grant >= 2", int'(lowRun >= 2), 1);
                    if (expQ.size() == 0) check("grant was expected", 0, 1);
                    else check("granted lane is entry", int'(bus.entryGrant), int'(expQ[0].entryLane));
                end
            end
            if (bus.gateOpen) lowRun = 0;
            else if (lowRun < 1000) lowRun++;
            prevGate = bus.gateOpen;
        end
    end

    // One gate transaction, started at a negedge while the arbiter is idle.
    // mode 0: car passes; 1: granted lane withdraws; 2: withdraw and sensor rise together.
    task automatic runTxn(input bit wantEntry, input bit wantExit, input int mode, input int passLen);
        bit eligE, eligX, lane;
        int highs, waited;
        eligE = wantEntry && (modelOcc != CAPACITY);
        eligX = wantExit && (modelOcc != 0);
        bus.entryReq = wantEntry;
        bus.exitReq  = wantExit;
        if (!eligE && !eligX) begin
            highs = 0;
            repeat (20) begin
                @(negedge clk);
                if (bus.gateOpen) highs++;
            end
            check("no grant while nothing eligible", highs, 0);
            bus.entryReq = 1'b0;
            bus.exitReq  = 1'b0;
            @(negedge clk);
            return;
        end
        lane = eligE && (!eligX || modelPtrEntry);
        if (mode == 1) begin
            expQ.push_back('{entryLane: lane, occAfter: modelOcc});
        end else begin
            modelOcc = lane ? modelOcc + 1 : modelOcc - 1;
            modelPtrEntry = !lane;
            expQ.push_back('{entryLane: lane, occAfter: modelOcc});
        end
        @(negedge clk);
        check("grant one cycle after request", int'(lane ? bus.entryGrant : bus.exitGrant), 1);
        waited = 0;
        while (!bus.gateOpen && waited < 4) begin
            @(negedge clk);
            waited++;
        end
        if (lane) bus.exitReq = 1'b0;
        else      bus.entryReq = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        case (mode)
            1: begin
                bus.entryReq = 1'b0;
                bus.exitReq  = 1'b0;
            end
            2: begin
                bus.entryReq   = 1'b0;
                bus.exitReq    = 1'b0;
                bus.passSensor = 1'b1;
                repeat (passLen) @(negedge clk);
                bus.passSensor = 1'b0;
            end
            default: begin
                bus.passSensor = 1'b1;
                @(negedge clk);
                bus.entryReq = 1'b0;
                bus.exitReq  = 1'b0;
                repeat (passLen - 1) @(negedge clk);
                bus.passSensor = 1'b0;
            end
        endcase
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (bus.gateOpen && waited < 10);
        check("gate closes after service", int'(bus.gateOpen), 0);
        @(negedge clk);
    endtask

    initial begin
        #400000;
        bad++;
        $display("FAIL global time limit: got running, expected finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        bus.entryReq   = 1'b0;
        bus.exitReq    = 1'b0;
        bus.passSensor = 1'b0;
        reset_n        = 1'b0;
        repeat (3) @(negedge clk);
        check("reset entryGrant", int'(bus.entryGrant), 0);
        check("reset exitGrant", int'(bus.exitGrant), 0);
        check("reset gateOpen", int'(bus.gateOpen), 0);
        check("reset occupancy", int'(bus.occupancy), 0);
        check("reset lotFull", int'(bus.lotFull), 0);
        check("reset timeoutAlarm", int'(bus.timeoutAlarm), 0);
        reset_n   = 1'b1;
        monitorOn = 1'b1;
        @(negedge clk);

        runTxn(1'b0, 1'b1, 0, 2);           // exit on an empty lot
        runTxn(1'b1, 1'b0, 0, 3);           // basic entry
        runTxn(1'b1, 1'b0, 0, 1);
        runTxn(1'b1, 1'b0, 0, 2);
        repeat (4) runTxn(1'b1, 1'b1, 0, 2); // contention from occupancy 3
        runTxn(1'b1, 1'b0, 1, 1);           // withdrawn before the sensor
        runTxn(1'b1, 1'b0, 2, 2);           // withdraw and sensor in the same cycle

        while (modelOcc < CAPACITY) runTxn(1'b1, 1'b0, 0, 1);
        runTxn(1'b1, 1'b0, 0, 1);           // full lot refuses entry
        runTxn(1'b1, 1'b1, 0, 2);           // exit still served while full
        runTxn(1'b1, 1'b0, 0, 1);

        repeat (60) begin
            runTxn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 2)), int'($urandom_range(1, 4)));
        end

        while (modelOcc >= CAPACITY) runTxn(1'b0, 1'b1, 0, 1);

`ifdef ARB_TIMEOUT_EN
        begin
            int highs;
            expQ.push_back('{entryLane: 1'b1, occAfter: modelOcc});
            bus.entryReq = 1'b1;
            highs = 0;
            @(negedge clk);
            while (bus.entryGrant && highs < 40) begin
                highs++;
                @(negedge clk);
            end
            check("watchdog grant cycles", highs, TIMEOUT);
            check("timeoutAlarm in ABORT", int'(bus.timeoutAlarm), 1);
            bus.entryReq = 1'b0;
            @(negedge clk);
            check("timeoutAlarm one cycle", int'(bus.timeoutAlarm), 0);
        end
`endif

        monitorOn = 1'b0;
        bus.entryReq = 1'b1;
        @(negedge clk);
        check("grant before mid-pass reset", int'(bus.entryGrant), 1);
        bus.passSensor = 1'b1;
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("reset mid-pass gateOpen", int'(bus.gateOpen), 0);
        check("reset mid-pass entryGrant", int'(bus.entryGrant), 0);
        check("reset mid-pass occupancy", int'(bus.occupancy), 0);
        check("reset mid-pass lotFull", int'(bus.lotFull), 0);
        bus.passSensor = 1'b0;
        bus.entryReq   = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        check("scoreboard drained", expQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/parking_lane_arbiter.md
# parking_lane_arbiter

Shares a single barrier gate between an entry lane and an exit lane of the parking lot and tracks lot occupancy. Each lane raises a request once its car is validated (the entry lane after correct-PIN acceptance). The arbiter grants the gate to one lane at a time, opens it, waits for the car to clear the pass sensor, then updates the occupancy count. It sits above the per-lane PIN/gate logic and owns the physical gate-open command.

## Interface
- `CAPACITY`, default 8: number of parking spaces; entry is refused when occupancy equals this value.
- `CNT_W`, default 4: occupancy counter width; must satisfy 2^CNT_W > CAPACITY.
- `TIMEOUT`, default 16: open-gate watchdog limit in cycles; used only with `ARB_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `entryReq` in 1: entry lane requests the gate; level-held until served.
- `exitReq` in 1: exit lane requests the gate; level-held until served.
- `passSensor` in 1: high while a car is under the gate.
- `entryGrant` out 1: gate granted to the entry lane.
- `exitGrant` out 1: gate granted to the exit lane.
- `gateOpen` out 1: gate open command.
- `occupancy` out CNT_W: cars currently parked.
- `lotFull` out 1: `occupancy == CAPACITY`.
- `timeoutAlarm` out 1: one-cycle pulse when the watchdog aborts a grant.

## Operation
- Reset state: IDLE, occupancy 0, priority pointer = EXIT, all outputs 0.
- Eligibility:
  - entry is eligible when `entryReq && !lotFull`.
  - exit is eligible when `exitReq && occupancy != 0`.
- One-hot FSM states: IDLE, ENTRY_OPEN, EXIT_OPEN, PASSING, CLOSE, ABORT.
- IDLE transitions:
  - One lane eligible: go to that lane's _OPEN state.
  - Both eligible: serve the lane named by the priority pointer.
  - Neither eligible: stay in IDLE.
- ENTRY_OPEN / EXIT_OPEN: `gateOpen` = 1 and the matching grant = 1.
  - `passSensor` = 1: go to PASSING.
  - Else, the granted lane's request drops: go to ABORT.
  - Else: stay.
- PASSING: `gateOpen` and the grant stay high. When `passSensor` = 0:
  - occupancy +1 for entry or −1 for exit;
  - the priority pointer moves to the other lane;
  - go to CLOSE.
- CLOSE: all outputs low for one cycle, then IDLE.
- ABORT: all outputs low for one cycle, then IDLE. Occupancy and the pointer are unchanged.
- Arithmetic:
  - occupancy never exceeds CAPACITY and never goes below 0; eligibility rules guarantee this.
  - the counter also saturates defensively at both bounds.
- Simultaneous `passSensor` rise and request drop in an _OPEN state: `passSensor` wins (go to PASSING).
- Request dropped during PASSING: ignored; the car is already committed.
- `lotFull` goes high while an entry is pending: the entry request is not granted; the exit request is served if eligible.
- `reset_n` low at any time: immediate return to the reset state. The gate closes and no count update occurs.

## Timing
- Request to grant: a request sampled in IDLE at edge N gives grant and `gateOpen` high after edge N (1-cycle latency).
- Count update: registered on the edge where PASSING sees `passSensor` = 0. `occupancy` and `lotFull` are valid the same cycle CLOSE begins.
- `lotFull` is combinational from registered `occupancy`.
- Spacing: at least 2 cycles with the gate low (CLOSE + IDLE) between consecutive grants.
- Grants are mutually exclusive in every cycle. `gateOpen` = `entryGrant | exitGrant`.
- `timeoutAlarm` is high exactly during the ABORT cycle that follows a watchdog expiry.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - a watchdog counter (width ≥ clog2(TIMEOUT+1)) clears on entry to an _OPEN state and increments every cycle in that state;
  - reaching TIMEOUT without `passSensor` forces ABORT and pulses `timeoutAlarm`;
  - PASSING is not watched.
- `ARB_TIMEOUT_EN` undefined:
  - no watchdog; an _OPEN state waits indefinitely for `passSensor` or a request drop;
  - `timeoutAlarm` is tied to 0.

## Test plan
- Basic entry, no timeout: after reset, `entryReq`=1. Expect `entryGrant` and `gateOpen` 1 cycle later. Pulse `passSensor` for 3 cycles. Expect `occupancy` 0→1, one CLOSE cycle, then outputs low.
- Contention and fairness: occupancy = 3, raise both requests together and hold them.
  - Expect exit granted first (pointer = EXIT) and occupancy 3→2.
  - Expect entry granted next and occupancy 2→3.
  - Expect grants strictly alternating thereafter.
- Full lot: fill to 8 with CAPACITY=8, then hold `entryReq`=1.
  - Expect `lotFull`=1 and no `entryGrant`.
  - Raise `exitReq` and complete the pass. Expect occupancy 7, then entry granted 2 cycles after CLOSE.
- Exit on empty: occupancy 0, `exitReq`=1 for 20 cycles. Expect no grant and occupancy stays 0.
- Abort and simultaneity:
  - In ENTRY_OPEN, drop `entryReq` with `passSensor` low: expect ABORT and occupancy unchanged.
  - Repeat with `passSensor` rising the same cycle the request drops: expect PASSING and occupancy +1.
- Watchdog and reset: with `ARB_TIMEOUT_EN`, TIMEOUT=16, hold the grant without `passSensor`.
  - Expect `timeoutAlarm` high for 1 cycle, with the grant still high through the 16th cycle after grant.
  - Assert `reset_n`=0 mid-PASSING: expect all outputs 0 immediately and occupancy 0.
